pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two cache controllers' pmem_* ports and physical memory, or the L2 if one is added later.
- Fixed priority goes to the data cache, with a starvation guard for the instruction cache.
- A grant is held for a whole line transaction, until pmem_resp.

Parameters:
ADDR_WIDTH, 16, byte address width of both requesters and memory
LINE_WIDTH, 128, cache line width in bits
STARVE_LIMIT, 4, max consecutive d-cache grants while an i-cache request waits (legal range 1..15)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-low; reset==0 forces reset state immediately
i_pmem_read  in  1  i-cache line read request
i_pmem_address  in  ADDR_WIDTH  i-cache line address
i_pmem_resp  out  1  i-cache transaction done
i_pmem_rdata  out  LINE_WIDTH  read line to i-cache
d_pmem_read  in  1  d-cache line read request
d_pmem_write  in  1  d-cache line writeback request
d_pmem_address  in  ADDR_WIDTH  d-cache line address
d_pmem_wdata  in  LINE_WIDTH  writeback line
d_pmem_resp  out  1  d-cache transaction done
d_pmem_rdata  out  LINE_WIDTH  read line to d-cache
pmem_read  out  1  memory read strobe
pmem_write  out  1  memory write strobe
pmem_address  out  ADDR_WIDTH  memory address
pmem_wdata  out  LINE_WIDTH  memory write line
pmem_resp  in  1  memory done
pmem_rdata  in  LINE_WIDTH  memory read line

Behaviour:
- States are IDLE, SERVE_I and SERVE_D. State is registered; outputs are a Moore function of state plus live requester/memory signals.
- Reset value is IDLE with the starvation counter at 0. While in IDLE:
  - pmem_read, pmem_write, i_pmem_resp and d_pmem_resp are 0.
  - pmem_address and pmem_wdata are 0.
- Request definitions: i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
- IDLE transitions, evaluated each edge:
  - Neither request pending: stay in IDLE.
  - Only one pending: go to that requester's SERVE state.
  - Both pending: go to SERVE_I if starve_cnt == STARVE_LIMIT, otherwise SERVE_D.
- SERVE_x outputs:
  - pmem_read/pmem_write/pmem_address/pmem_wdata are the granted requester's live signals.
  - SERVE_I drives pmem_write=0 and pmem_wdata=0.
  - x_pmem_resp = pmem_resp (same cycle, combinational). The other resp is held at 0.
- Read data: i_pmem_rdata and d_pmem_rdata both carry pmem_rdata unconditionally; only resp qualifies it.
- SERVE_x exit: go to IDLE on the edge where pmem_resp==1. Also go to IDLE if the granted requester drops its request before resp (abort); the memory strobe drops with it.
- Mandatory IDLE cycle: every transaction is followed by at least one IDLE cycle. This lets the cache controller leave its allocate/writeback state before requests are re-sampled. A request is never sampled in the resp cycle.
- Latency: request first seen in IDLE at cycle N gives pmem strobe at N+1. Best-case turnaround for the losing requester is the winner's transaction + 1 cycle.
- Starvation counter (width 4):
  - Increments on each IDLE->SERVE_D transition taken while i_req==1, saturating at STARVE_LIMIT.
  - Clears on IDLE->SERVE_I.
  - Clears in any IDLE cycle with i_req==0.
- d_pmem_read and d_pmem_write both high is illegal. The arbiter forwards both strobes unmodified; the bench flags it.
- Reset asserted mid-transaction: state goes to IDLE and strobes drop asynchronously. No resp is generated; the caches are reset by the same signal.
- pmem_resp arriving in IDLE is ignored; neither resp is asserted.

Optional Feature:
- Macro: PMEM_ARB_PERF_CNT_EN.
- Defined: adds outputs i_grant_cnt, d_grant_cnt and conflict_cnt, each 32-bit and reset to 0.
  - i_grant_cnt and d_grant_cnt increment on entry to SERVE_I and SERVE_D respectively.
  - conflict_cnt increments on every IDLE exit where both requests were pending.
  - All three saturate at 0xFFFFFFFF.
- Undefined: the ports and logic are absent; arbitration is identical.

Decomposition:
- Package pmem_arb_types: arb_state_t enum (IDLE, SERVE_I, SERVE_D), STARVE_CNT_W=4, and default widths.
- One sub-module, pmem_arb_starve_ctr. It contains the saturating starvation counter; inputs are inc, clr and limit, and the output is at_limit.

Test Plan:
- Only i-cache reads 0x1230 and memory responds after 5 cycles: pmem_read at N+1 with address 0x1230; i_pmem_resp only in the resp cycle; d_pmem_resp stays 0; IDLE follows.
- Both request in the same cycle, STARVE_LIMIT=4, starve_cnt=0: SERVE_D is granted first. After the d writeback resp there is one IDLE cycle, then SERVE_I.
- d_req held continuously while i_req is pending across 5 d transactions: grants are D,D,D,D,I (the fifth grant goes to i once the counter reaches 4), then the counter reads 0.
- Reset pulled low for 1 cycle mid SERVE_D before resp: pmem_write drops without waiting for a clock; state is IDLE; no resp; a later request starts cleanly.
- pmem_resp asserted in IDLE with no requests: no resp outputs and no state change. With PMEM_ARB_PERF_CNT_EN, three contended grants give conflict_cnt=3 and d_grant_cnt equal to the number of SERVE_D entries.

Source files
------------

// File: rtl/pmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pmem_arb_types (package)
// Purpose  : Shared types and default sizes for the physical-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package pmem_arb_types;

   localparam int STARVE_CNT_W     = 4;
   localparam int PERF_CNT_W       = 32;
   localparam int DEF_ADDR_WIDTH   = 16;
   localparam int DEF_LINE_WIDTH   = 128;
   localparam int DEF_STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/pmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : pmem_arbiter_if
// Purpose  : Bundles the i-cache, d-cache and physical-memory line buses that
//            meet at the arbiter. The master view belongs to the arbiter, the
//            slave view to the caches and memory around it.
// Revision : 1.0 - initial release
// ============================================================================
interface pmem_arbiter_if #(
   parameter int ADDR_WIDTH = pmem_arb_types::DEF_ADDR_WIDTH,
   parameter int LINE_WIDTH = pmem_arb_types::DEF_LINE_WIDTH
);
   // i-cache side (read only)
   logic                  i_pmem_read;
   logic [ADDR_WIDTH-1:0] i_pmem_address;
   logic                  i_pmem_resp;
   logic [LINE_WIDTH-1:0] i_pmem_rdata;
   // d-cache side (read / writeback)
   logic                  d_pmem_read;
   logic                  d_pmem_write;
   logic [ADDR_WIDTH-1:0] d_pmem_address;
   logic [LINE_WIDTH-1:0] d_pmem_wdata;
   logic                  d_pmem_resp;
   logic [LINE_WIDTH-1:0] d_pmem_rdata;
   // physical memory side
   logic                  pmem_read;
   logic                  pmem_write;
   logic [ADDR_WIDTH-1:0] pmem_address;
   logic [LINE_WIDTH-1:0] pmem_wdata;
   logic                  pmem_resp;
   logic [LINE_WIDTH-1:0] pmem_rdata;

   modport master (
      input  i_pmem_read, i_pmem_address,
      input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      input  pmem_resp, pmem_rdata,
      output i_pmem_resp, i_pmem_rdata, d_pmem_resp, d_pmem_rdata,
      output pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport slave (
      output i_pmem_read, i_pmem_address,
      output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      output pmem_resp, pmem_rdata,
      input  i_pmem_resp, i_pmem_rdata, d_pmem_resp, d_pmem_rdata,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata
   );

endinterface
`default_nettype wire

// File: rtl/pmem_arbiter_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : pmem_arb_starve_ctr
// Purpose  : Saturating count of d-cache grants taken while the i-cache was
//            waiting. at_limit_o tells the arbiter to hand the next contended
//            grant to the i-cache.
// Revision : 1.0 - initial release
// ============================================================================
module pmem_arb_starve_ctr
   import pmem_arb_types::*;
(
   input  logic                    clk,
   input  logic                    reset,      // asynchronous, active-low
   input  logic                    inc_i,
   input  logic                    clr_i,
   input  logic [STARVE_CNT_W-1:0] limit_i,
   output logic                    at_limit_o
);

   logic [STARVE_CNT_W-1:0] cnt_q;
   logic [STARVE_CNT_W-1:0] cnt_d;

   // clear wins over increment; increment stops once the limit is reached
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < limit_i)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q >= limit_i);

endmodule
`default_nettype wire

// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pmem_arbiter
// Purpose  : Shares one physical-memory line port between the i-cache and the
//            d-cache. The d-cache has fixed priority; a starvation counter
//            forces an i-cache grant after STARVE_LIMIT consecutive contended
//            d-cache grants. A grant lasts until pmem_resp (or until the
//            granted requester withdraws), and is always followed by at least
//            one IDLE cycle.
//            Optional macro PMEM_ARB_PERF_CNT_EN adds saturating 32-bit grant
//            and conflict counters.
// Revision : 1.0 - initial release
// ============================================================================
module pmem_arbiter
   import pmem_arb_types::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT   // legal range 1..15
) (
   input  logic                  clk,
   input  logic                  reset,            // asynchronous, active-low
`ifdef PMEM_ARB_PERF_CNT_EN
   output logic [PERF_CNT_W-1:0] i_grant_cnt,
   output logic [PERF_CNT_W-1:0] d_grant_cnt,
   output logic [PERF_CNT_W-1:0] conflict_cnt,
`endif
   pmem_arbiter_if.master        bus
);

   localparam logic [STARVE_CNT_W-1:0] c_limit = STARVE_CNT_W'(STARVE_LIMIT);

   arb_state_t            state_q;
   arb_state_t            state_d;

   logic                  w_i_req;
   logic                  w_d_req;
   logic                  w_at_limit;
   logic                  w_starve_inc;
   logic                  w_starve_clr;

   logic                  w_read;
   logic                  w_write;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [LINE_WIDTH-1:0] w_wdata;
   logic                  w_i_resp;
   logic                  w_d_resp;

   assign w_i_req = bus.i_pmem_read;
   assign w_d_req = bus.d_pmem_read | bus.d_pmem_write;

   // grant decision in IDLE; a SERVE state ends on resp or on withdrawal
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (w_i_req && w_d_req) begin
               state_d = w_at_limit ? SERVE_I : SERVE_D;
            end else if (w_d_req) begin
               state_d = SERVE_D;
            end else if (w_i_req) begin
               state_d = SERVE_I;
            end
         end
         SERVE_I: begin
            if (bus.pmem_resp || !w_i_req) begin
               state_d = IDLE;
            end
         end
         SERVE_D: begin
            if (bus.pmem_resp || !w_d_req) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // arbitration state register; reset drops every strobe immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // the counter only moves in IDLE cycles, where grants are decided
   assign w_starve_inc = (state_q == IDLE) && (state_d == SERVE_D) && w_i_req;
   assign w_starve_clr = (state_q == IDLE) && ((state_d == SERVE_I) || !w_i_req);

   pmem_arb_starve_ctr u_starve (
      .clk        (clk),
      .reset      (reset),
      .inc_i      (w_starve_inc),
      .clr_i      (w_starve_clr),
      .limit_i    (c_limit),
      .at_limit_o (w_at_limit)
   );

   // memory strobes follow the granted requester's live signals
   always_comb begin
      w_read   = 1'b0;
      w_write  = 1'b0;
      w_addr   = '0;
      w_wdata  = '0;
      w_i_resp = 1'b0;
      w_d_resp = 1'b0;
      case (state_q)
         SERVE_I: begin
            w_read   = bus.i_pmem_read;
            w_addr   = bus.i_pmem_address;
            w_i_resp = bus.pmem_resp;
         end
         SERVE_D: begin
            w_read   = bus.d_pmem_read;
            w_write  = bus.d_pmem_write;
            w_addr   = bus.d_pmem_address;
            w_wdata  = bus.d_pmem_wdata;
            w_d_resp = bus.pmem_resp;
         end
         default: ;
      endcase
   end

   assign bus.pmem_read    = w_read;
   assign bus.pmem_write   = w_write;
   assign bus.pmem_address = w_addr;
   assign bus.pmem_wdata   = w_wdata;
   assign bus.i_pmem_resp  = w_i_resp;
   assign bus.d_pmem_resp  = w_d_resp;
   // read data is broadcast; only resp qualifies it
   assign bus.i_pmem_rdata = bus.pmem_rdata;
   assign bus.d_pmem_rdata = bus.pmem_rdata;

`ifdef PMEM_ARB_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] i_grant_cnt_q;
   logic [PERF_CNT_W-1:0] d_grant_cnt_q;
   logic [PERF_CNT_W-1:0] conflict_cnt_q;
   logic                  w_i_entry;
   logic                  w_d_entry;
   logic                  w_conflict;

   assign w_i_entry  = (state_q == IDLE) && (state_d == SERVE_I);
   assign w_d_entry  = (state_q == IDLE) && (state_d == SERVE_D);
   // IDLE with both requests pending always leaves IDLE on this edge
   assign w_conflict = (state_q == IDLE) && w_i_req && w_d_req;

   // saturating grant and conflict statistics
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         i_grant_cnt_q  <= '0;
         d_grant_cnt_q  <= '0;
         conflict_cnt_q <= '0;
      end else begin
         if (w_i_entry && (i_grant_cnt_q != '1)) begin
            i_grant_cnt_q <= i_grant_cnt_q + 1'b1;
         end
         if (w_d_entry && (d_grant_cnt_q != '1)) begin
            d_grant_cnt_q <= d_grant_cnt_q + 1'b1;
         end
         if (w_conflict && (conflict_cnt_q != '1)) begin
            conflict_cnt_q <= conflict_cnt_q + 1'b1;
         end
      end
   end

   assign i_grant_cnt  = i_grant_cnt_q;
   assign d_grant_cnt  = d_grant_cnt_q;
   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_arbiter
// Purpose  : Self-checking bench for pmem_arbiter: per-cycle vector table,
//            directed starvation and reset sequences, and a randomized run
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_arbiter;

   localparam int c_limit = 4;
   localparam int c_vw    = 404;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   pmem_arbiter_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) bus ();

`ifdef PMEM_ARB_PERF_CNT_EN
   logic [31:0] i_gc;
   logic [31:0] d_gc;
   logic [31:0] cf_c;
`endif

   pmem_arbiter #(
      .ADDR_WIDTH   (16),
      .LINE_WIDTH   (128),
      .STARVE_LIMIT (c_limit)
   ) dut (
      .clk          (clk),
      .reset        (reset),
`ifdef PMEM_ARB_PERF_CNT_EN
      .i_grant_cnt  (i_gc),
      .d_grant_cnt  (d_gc),
      .conflict_cnt (cf_c),
`endif
      .bus          (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, required finish before 1ms");
      $fatal(1, "watchdog");
   end

   // observed outputs packed as {rd, wr, addr, wdata, i_resp, d_resp, i_rdata, d_rdata}
   function automatic logic [c_vw-1:0] act_bits();
      return {bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata,
              bus.i_pmem_resp, bus.d_pmem_resp, bus.i_pmem_rdata, bus.d_pmem_rdata};
   endfunction

   task automatic check(input string name, input logic [c_vw-1:0] act, input logic [c_vw-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.i_pmem_read    = 1'b0;
      bus.i_pmem_address = '0;
      bus.d_pmem_read    = 1'b0;
      bus.d_pmem_write   = 1'b0;
      bus.d_pmem_address = '0;
      bus.d_pmem_wdata   = '0;
      bus.pmem_resp      = 1'b0;
      bus.pmem_rdata     = '0;
   endtask

   task automatic do_reset(input bit check_state);
      clear_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      if (check_state) check("reset_state", act_bits(), '0);
      #1 reset = 1'b1;
   endtask

   // ------------------------------------------------------------------------
   // per-cycle vector table
   // ------------------------------------------------------------------------
   typedef struct {
      logic        i_rd;
      logic [15:0] i_addr;
      logic        d_rd;
      logic        d_wr;
      logic [15:0] d_addr;
      logic [127:0] d_wdata;
      logic        resp;
      logic        e_rd;
      logic        e_wr;
      logic [15:0] e_addr;
      logic [127:0] e_wdata;
      logic        e_ir;
      logic        e_dr;
   } vec_t;

   function automatic vec_t mk(logic i_rd, logic [15:0] i_addr, logic d_rd, logic d_wr,
                               logic [15:0] d_addr, logic [127:0] d_wdata, logic resp,
                               logic e_rd, logic e_wr, logic [15:0] e_addr,
                               logic [127:0] e_wdata, logic e_ir, logic e_dr);
      vec_t v;
      v.i_rd = i_rd; v.i_addr = i_addr; v.d_rd = d_rd; v.d_wr = d_wr;
      v.d_addr = d_addr; v.d_wdata = d_wdata; v.resp = resp;
      v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wdata = e_wdata;
      v.e_ir = e_ir; v.e_dr = e_dr;
      return v;
   endfunction

   // ------------------------------------------------------------------------
   // reference model: who owns the memory port, and how many contended
   // d-cache wins the waiting i-cache has suffered
   // ------------------------------------------------------------------------
   int owner;      // 0 nobody, 1 i-cache, 2 d-cache
   int dwins;
   int m_ig, m_dg, m_cf;

   function automatic logic [c_vw-1:0] model_out(logic i_rd, logic [15:0] ia, logic d_rd,
                                                 logic d_wr, logic [15:0] da, logic [127:0] dw,
                                                 logic rsp, logic [127:0] rd);
      logic [127:0] z;
      z = '0;
      if (owner == 1) return {i_rd, 1'b0, ia, z, rsp, 1'b0, rd, rd};
      if (owner == 2) return {d_rd, d_wr, da, dw, 1'b0, rsp, rd, rd};
      return {1'b0, 1'b0, 16'h0, z, 1'b0, 1'b0, rd, rd};
   endfunction

   task automatic model_step(logic ireq, logic dreq, logic rsp);
      if (owner == 0) begin
         if (ireq && dreq) begin
            m_cf++;
            owner = (dwins == c_limit) ? 1 : 2;
         end else if (ireq) begin
            owner = 1;
         end else if (dreq) begin
            owner = 2;
         end
         if (owner == 1) m_ig++;
         if (owner == 2) m_dg++;
         if (!ireq || owner == 1) dwins = 0;
         else if (owner == 2 && dwins < c_limit) dwins++;
      end else if (rsp || (owner == 1 && !ireq) || (owner == 2 && !dreq)) begin
         owner = 0;
      end
   endtask

   initial begin
      vec_t         tbl[$];
      logic [127:0] wa, wb, rdv;
      int           grants[5];
      int           ngr, age;
      logic         strobe_seen;
      bit           i_on, d_on, d_is_wr, last_ir, last_dr;
      logic [c_vw-1:0] exp;

      total = 0;
      bad   = 0;
      reset = 1'b0;
      do_reset(1'b1);

      wa = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      wb = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
      //           i_rd i_addr    d_rd d_wr d_addr    d_wdata resp | rd wr addr     wdata  ir dr
      // i-cache read of 0x1230, memory answers 5 cycles after the strobe
      tbl.push_back(mk(1, 16'h1230, 0, 0, 16'h0000, '0, 0,   0, 0, 16'h0000, '0, 0, 0));
      tbl.push_back(mk(1, 16'h1230, 0, 0, 16'h0000, '0, 0,   1, 0, 16'h1230, '0, 0, 0));
      tbl.push_back(mk(1, 16'h1230, 0, 0, 16'h0000, '0, 0,   1, 0, 16'h1230, '0, 0, 0));
      tbl.push_back(mk(1, 16'h1230, 0, 0, 16'h0000, '0, 0,   1, 0, 16'h1230, '0, 0, 0));
      tbl.push_back(mk(1, 16'h1230, 0, 0, 16'h0000, '0, 0,   1, 0, 16'h1230, '0, 0, 0));
      tbl.push_back(mk(1, 16'h1230, 0, 0, 16'h0000, '0, 0,   1, 0, 16'h1230, '0, 0, 0));
      tbl.push_back(mk(1, 16'h1230, 0, 0, 16'h0000, '0, 1,   1, 0, 16'h1230, '0, 1, 0));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, '0, 0,   0, 0, 16'h0000, '0, 0, 0));
      // stray resp in IDLE is ignored
      tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, '0, 1,   0, 0, 16'h0000, '0, 0, 0));
      // d-cache writeback
      tbl.push_back(mk(0, 16'h0000, 0, 1, 16'h2000, wa, 0,   0, 0, 16'h0000, '0, 0, 0));
      tbl.push_back(mk(0, 16'h0000, 0, 1, 16'h2000, wa, 0,   0, 1, 16'h2000, wa, 0, 0));
      tbl.push_back(mk(0, 16'h0000, 0, 1, 16'h2000, wa, 1,   0, 1, 16'h2000, wa, 0, 1));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, '0, 0,   0, 0, 16'h0000, '0, 0, 0));
      // both request together: d first, one IDLE cycle, then i (wdata zeroed)
      tbl.push_back(mk(1, 16'h0040, 1, 0, 16'h0080, wb, 0,   0, 0, 16'h0000, '0, 0, 0));
      tbl.push_back(mk(1, 16'h0040, 1, 0, 16'h0080, wb, 0,   1, 0, 16'h0080, wb, 0, 0));
      tbl.push_back(mk(1, 16'h0040, 1, 0, 16'h0080, wb, 1,   1, 0, 16'h0080, wb, 0, 1));
      tbl.push_back(mk(1, 16'h0040, 0, 0, 16'h0080, wb, 0,   0, 0, 16'h0000, '0, 0, 0));
      tbl.push_back(mk(1, 16'h0040, 0, 0, 16'h0080, wb, 0,   1, 0, 16'h0040, '0, 0, 0));
      tbl.push_back(mk(1, 16'h0040, 0, 0, 16'h0080, wb, 1,   1, 0, 16'h0040, '0, 1, 0));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0080, wb, 0,   0, 0, 16'h0000, '0, 0, 0));
      // d-cache withdraws its writeback before resp, then retries
      tbl.push_back(mk(0, 16'h0000, 0, 1, 16'h5000, wa, 0,   0, 0, 16'h0000, '0, 0, 0));
      tbl.push_back(mk(0, 16'h0000, 0, 1, 16'h5000, wa, 0,   0, 1, 16'h5000, wa, 0, 0));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h5000, wa, 0,   0, 0, 16'h5000, wa, 0, 0));
      tbl.push_back(mk(0, 16'h0000, 0, 1, 16'h5000, wa, 0,   0, 0, 16'h0000, '0, 0, 0));
      tbl.push_back(mk(0, 16'h0000, 0, 1, 16'h5000, wa, 0,   0, 1, 16'h5000, wa, 0, 0));
      tbl.push_back(mk(0, 16'h0000, 0, 1, 16'h5000, wa, 1,   0, 1, 16'h5000, wa, 0, 1));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, '0, 0,   0, 0, 16'h0000, '0, 0, 0));

      for (int k = 0; k < tbl.size(); k++) begin
         @(posedge clk);
         #1;
         rdv = {4{32'hA5A5_0000 + 32'(k)}};
         bus.i_pmem_read    = tbl[k].i_rd;
         bus.i_pmem_address = tbl[k].i_addr;
         bus.d_pmem_read    = tbl[k].d_rd;
         bus.d_pmem_write   = tbl[k].d_wr;
         bus.d_pmem_address = tbl[k].d_addr;
         bus.d_pmem_wdata   = tbl[k].d_wdata;
         bus.pmem_resp      = tbl[k].resp;
         bus.pmem_rdata     = rdv;
         @(negedge clk);
         check($sformatf("vec%0d", k), act_bits(),
               {tbl[k].e_rd, tbl[k].e_wr, tbl[k].e_addr, tbl[k].e_wdata,
                tbl[k].e_ir, tbl[k].e_dr, rdv, rdv});
      end

      // ------------------------------------------------------------------
      // starvation: d-cache requests back-to-back while the i-cache waits
      // ------------------------------------------------------------------
      @(posedge clk);
      #1;
      clear_inputs();
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 16'h0100;
      bus.d_pmem_read    = 1'b1;
      bus.d_pmem_address = 16'h0200;
      ngr = 0;
      age = 0;
      for (int cyc = 0; cyc < 100 && ngr < 5; cyc++) begin
         @(negedge clk);
         strobe_seen = bus.pmem_read | bus.pmem_write;
         if (strobe_seen && bus.pmem_resp) begin
            grants[ngr] = (bus.pmem_address == 16'h0100) ? 1 : 2;
            if (ngr == 3) check("starve_cnt_sat", c_vw'(dut.u_starve.cnt_q), c_vw'(4));
            if (ngr == 4) check("starve_cnt_clr", c_vw'(dut.u_starve.cnt_q), c_vw'(0));
            ngr++;
         end
         @(posedge clk);
         #1;
         if (bus.pmem_resp) begin
            bus.pmem_resp = 1'b0;
            age = 0;
            if (ngr == 5) bus.i_pmem_read = 1'b0;
         end else if (strobe_seen) begin
            age++;
            if (age >= 2) bus.pmem_resp = 1'b1;
         end
      end
      if (ngr < 5) begin
         total++;
         bad++;
         $display("FAIL starve_timeout: got %0d grants, required 5", ngr);
      end else begin
         for (int g = 0; g < 5; g++)
            check($sformatf("starve_grant%0d", g), c_vw'(grants[g]), c_vw'((g == 4) ? 1 : 2));
      end
      clear_inputs();
      repeat (3) @(posedge clk);

      // ------------------------------------------------------------------
      // asynchronous reset in the middle of a d-cache writeback
      // ------------------------------------------------------------------
      #1;
      bus.d_pmem_write   = 1'b1;
      bus.d_pmem_address = 16'h3000;
      bus.d_pmem_wdata   = wb;
      @(negedge clk);
      @(negedge clk);
      check("rst_pre_write", c_vw'(bus.pmem_write), c_vw'(1));
      #2;
      reset         = 1'b0;
      bus.pmem_resp = 1'b1;
      #1;
      check("rst_async_drop",
            c_vw'({bus.pmem_read, bus.pmem_write, bus.i_pmem_resp, bus.d_pmem_resp, bus.pmem_address}),
            '0);
      #9;
      reset            = 1'b1;
      bus.pmem_resp    = 1'b0;
      bus.d_pmem_write = 1'b0;
      @(negedge clk);
      check("rst_idle", act_bits(), '0);
      @(posedge clk);
      #1;
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 16'h4440;
      @(negedge clk);
      check("rst_new_wait", c_vw'(bus.pmem_read), c_vw'(0));
      @(negedge clk);
      check("rst_new_grant", c_vw'({bus.pmem_read, bus.pmem_address}), c_vw'({1'b1, 16'h4440}));
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b1;
      @(negedge clk);
      check("rst_new_resp", c_vw'({bus.i_pmem_resp, bus.d_pmem_resp}), c_vw'(2'b10));

      // ------------------------------------------------------------------
      // randomized traffic against the reference model
      // ------------------------------------------------------------------
      do_reset(1'b0);
      owner = 0; dwins = 0; m_ig = 0; m_dg = 0; m_cf = 0;
      i_on = 0; d_on = 0; d_is_wr = 0; last_ir = 0; last_dr = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk);
         #1;
         // requesters leave after their resp, sometimes abort, sometimes start
         if (i_on) begin
            if (last_ir || $urandom_range(31) == 0) i_on = 1'b0;
         end else if ($urandom_range(1) == 0) begin
            i_on = 1'b1;
            bus.i_pmem_address = 16'($urandom);
         end
         if (d_on) begin
            if (last_dr) begin
               if ($urandom_range(3) != 0) d_on = 1'b0;
            end else if ($urandom_range(31) == 0) begin
               d_on = 1'b0;
            end
         end else if ($urandom_range(1) == 0) begin
            d_on = 1'b1;
            d_is_wr = 1'($urandom_range(1));
            bus.d_pmem_address = 16'($urandom);
            bus.d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
         end
         bus.i_pmem_read  = i_on;
         bus.d_pmem_read  = d_on & ~d_is_wr;
         bus.d_pmem_write = d_on & d_is_wr;
         bus.pmem_resp    = ($urandom_range(2) == 0);
         bus.pmem_rdata   = {$urandom, $urandom, $urandom, $urandom};
         #3;
         exp = model_out(bus.i_pmem_read, bus.i_pmem_address, bus.d_pmem_read,
                         bus.d_pmem_write, bus.d_pmem_address, bus.d_pmem_wdata,
                         bus.pmem_resp, bus.pmem_rdata);
         check($sformatf("rand%0d", cyc), act_bits(), exp);
         last_ir = exp[c_vw-147];
         last_dr = exp[c_vw-148];
         model_step(bus.i_pmem_read, bus.d_pmem_read | bus.d_pmem_write, bus.pmem_resp);
      end

`ifdef PMEM_ARB_PERF_CNT_EN
      @(negedge clk);
      check("perf_i_grant",  c_vw'(i_gc), c_vw'(m_ig));
      check("perf_d_grant",  c_vw'(d_gc), c_vw'(m_dg));
      check("perf_conflict", c_vw'(cf_c), c_vw'(m_cf));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
